// File: rtl/collatz_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// collatz_run_ctrl_if
//   Handshake between the run sequencer and the Collatz range datapath.
//   Signals:
//     go     1-cycle start pulse to the range block
//     start  base n while running; result RAM read address once done
//     done   range finished, result RAM readable
//     count  iteration count read from the RAM at address 'start'
//   Modports:
//     master  sequencer side (drives go/start)
//     slave   range side (drives done/count)
// ---------------------------------------------------------------------------
interface collatz_run_ctrl_if;
  logic        go;
  logic [31:0] start;
  logic        done;
  logic [15:0] count;

  modport master (output go, output start, input done, input count);
  modport slave  (input go, input start, output done, output count);
endinterface

// File: rtl/collatz_run_ctrl.sv
// ---------------------------------------------------------------------------
// collatz_run_ctrl
//   Sequencer for the Collatz range datapath. Launches a run from a
//   switch-selected base n, waits for completion, sweeps the result RAM for
//   the maximum iteration count, then serves user / auto-stepped reads for
//   the hex display.
//   Ports:
//     clk, reset   system clock, synchronous active-high reset
//     base         base n from the switches
//     run          click: start a new run
//     inc/dec/clr  pulses: offset +1 / -1 / =0
//     auto_en      level: auto-step the offset every SCAN_DIV cycles in SHOW
//     rng          range handshake (go, start, done, count)
//     busy         high while launching, running or sweeping
//     disp_n       n currently shown (base_q + offset, 12-bit wrap)
//     disp_count   latched count for disp_n
//     disp_valid   disp_count belongs to the current disp_n
//     max_count    largest count over the last completed run
//     max_addr     offset of max_count (lowest offset on ties)
// ---------------------------------------------------------------------------
module collatz_run_ctrl #(
  parameter int WORDS     = 256,
  parameter int ADDR_BITS = 8,
  parameter int RD_LAT    = 1,
  parameter int SCAN_DIV  = 10_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [9:0]             base,
  input  logic                   run,
  input  logic                   inc,
  input  logic                   dec,
  input  logic                   clr,
  input  logic                   auto_en,
  collatz_run_ctrl_if.master     rng,
  output logic                   busy,
  output logic [11:0]            disp_n,
  output logic [15:0]            disp_count,
  output logic                   disp_valid,
  output logic [15:0]            max_count,
  output logic [ADDR_BITS-1:0]   max_addr
);

  // phase counts 0..RD_LAT while waiting for read data, RD_LAT+1 = latched
  localparam int CW = $clog2(RD_LAT + 2);
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam logic [CW-1:0]        LAT_C     = CW'(RD_LAT);
  localparam logic [SW-1:0]        SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(WORDS - 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, SWEEP, SHOW} state_t;

  state_t                 state, state_nxt;
  logic [9:0]             base_q, base_q_nxt;
  logic [ADDR_BITS-1:0]   offset, offset_nxt;
  logic [ADDR_BITS-1:0]   addr, addr_nxt;
  logic [CW-1:0]          phase, phase_nxt;
  logic [1:0]             hold_cnt, hold_cnt_nxt;
  logic [SW-1:0]          scan_cnt, scan_cnt_nxt;
  logic                   scan_tick;
  logic                   offset_changed;
  logic [15:0]            disp_count_nxt;
  logic                   disp_valid_nxt;
  logic [15:0]            max_count_nxt;
  logic [ADDR_BITS-1:0]   max_addr_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q     <= '0;
      offset     <= '0;
      addr       <= '0;
      phase      <= '0;
      hold_cnt   <= '0;
      scan_cnt   <= '0;
      disp_count <= '0;
      disp_valid <= 1'b0;
      max_count  <= '0;
      max_addr   <= '0;
    end else begin
      base_q     <= base_q_nxt;
      offset     <= offset_nxt;
      addr       <= addr_nxt;
      phase      <= phase_nxt;
      hold_cnt   <= hold_cnt_nxt;
      scan_cnt   <= scan_cnt_nxt;
      disp_count <= disp_count_nxt;
      disp_valid <= disp_valid_nxt;
      max_count  <= max_count_nxt;
      max_addr   <= max_addr_nxt;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_nxt      = state;
    base_q_nxt     = base_q;
    offset_nxt     = offset;
    addr_nxt       = addr;
    phase_nxt      = phase;
    hold_cnt_nxt   = hold_cnt;
    scan_cnt_nxt   = '0;
    scan_tick      = 1'b0;
    offset_changed = 1'b0;
    disp_count_nxt = disp_count;
    disp_valid_nxt = disp_valid;
    max_count_nxt  = max_count;
    max_addr_nxt   = max_addr;
    rng.go         = 1'b0;
    rng.start      = {22'b0, base_q};
    busy           = 1'b0;
    disp_n         = 12'(base_q) + 12'(offset);

    case (state)
      IDLE: begin
        rng.start = {22'b0, base};
        disp_n    = {2'b0, base};
        if (run) begin
          base_q_nxt = base;
          state_nxt  = LAUNCH;
        end
      end

      LAUNCH: begin
        rng.go         = 1'b1;
        busy           = 1'b1;
        hold_cnt_nxt   = '0;
        disp_valid_nxt = 1'b0;
        state_nxt      = RUN;
      end

      RUN: begin
        busy = 1'b1;
        // done may still be high from the previous run for two cycles
        if (hold_cnt != 2'd2) begin
          hold_cnt_nxt = hold_cnt + 2'd1;
        end else if (rng.done) begin
          state_nxt     = SWEEP;
          addr_nxt      = '0;
          phase_nxt     = '0;
          max_count_nxt = '0;
          max_addr_nxt  = '0;
        end
      end

      SWEEP: begin
        busy      = 1'b1;
        rng.start = 32'(addr);
        // a dropped done restarts the read of the current address
        if (!rng.done) begin
          phase_nxt = '0;
        end else if (phase != LAT_C) begin
          phase_nxt = phase + 1'b1;
        end else begin
          phase_nxt = '0;
          if (rng.count > max_count) begin
            max_count_nxt = rng.count;
            max_addr_nxt  = addr;
          end
          if (addr == LAST_ADDR) begin
            state_nxt      = SHOW;
            offset_nxt     = '0;
            disp_valid_nxt = 1'b0;
          end else begin
            addr_nxt = addr + 1'b1;
          end
        end
      end

      SHOW: begin
        rng.start = 32'(offset);
        if (!rng.done) begin
          disp_valid_nxt = 1'b0;
          phase_nxt      = '0;
        end else begin
          if (auto_en) begin
            if (scan_cnt == SCAN_LAST) begin
              scan_tick    = 1'b1;
              scan_cnt_nxt = '0;
            end else begin
              scan_cnt_nxt = scan_cnt + 1'b1;
            end
          end
          if (run) begin
            base_q_nxt     = base;
            disp_valid_nxt = 1'b0;
            state_nxt      = LAUNCH;
          end else begin
            offset_changed = 1'b1;
            if (clr)            offset_nxt = '0;
            else if (inc)       offset_nxt = (offset == LAST_ADDR) ? '0 : offset + 1'b1;
            else if (dec)       offset_nxt = (offset == '0) ? LAST_ADDR : offset - 1'b1;
            else if (scan_tick) offset_nxt = (offset == LAST_ADDR) ? '0 : offset + 1'b1;
            else                offset_changed = 1'b0;

            if (offset_changed) begin
              disp_valid_nxt = 1'b0;
              phase_nxt      = '0;
            end else if (phase == LAT_C) begin
              disp_count_nxt = rng.count;
              disp_valid_nxt = 1'b1;
              phase_nxt      = phase + 1'b1;
            end else if (phase < LAT_C) begin
              phase_nxt = phase + 1'b1;
            end
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
